parity_rx: RTL and testbench

Serial receiver and parity checker, the receive end of the team's parity generator and parallel-to-serial path. It deserialises a start-bit framed stream qualified by a bit strobe and recomputes parity over the data bits. It flags parity and framing errors and presents the parallel word with a one-cycle valid pulse to downstream logic.

---
 rtl/parity_rx.sv | 130 +++++++++++++
 tb/tb_parity_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_rx.sv
// parity_rx: serial receiver and parity checker.
//
// Deserialises a start-bit framed stream qualified by bit_en. A frame is
// start(0), DATA_W data bits, one parity bit and stop(1). Parity is recomputed
// over the data bits and compared with the received parity bit.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   bit_en     qualifies ser_in; a bit is accepted only when bit_en=1
//   ser_in     serial line, idles high
//   even_odd   0 = even parity, 1 = odd parity; latched with the start bit
//   data_out   last received word, updated only with data_valid
//   data_valid one-cycle pulse: data_out, par_err and frame_err just loaded
//   par_err    received parity bit mismatched the recomputed parity
//   frame_err  stop bit was sampled as 0
//   busy       start bit accepted, stop bit not yet accepted
module parity_rx #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              ser_in,
   input  logic              even_odd,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              par_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int unsigned    CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StData   = 2'd1;
   localparam logic [1:0] StParity = 2'd2;
   localparam logic [1:0] StStop   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              par_bit_q, par_bit_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      par_bit_d = par_bit_q;
      data_d    = data_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      valid_d   = 1'b0;

      if (bit_en) begin
         case (state_q)
            StIdle: begin
               if (!ser_in) begin
                  // Parity mode is frozen for the whole frame here.
                  mode_d  = even_odd;
                  cnt_d   = '0;
                  state_d = StData;
               end
            end
            StData: begin
               shift_d = MSB_FIRST ? {shift_q[DATA_W-2:0], ser_in}
                                   : {ser_in, shift_q[DATA_W-1:1]};
               if (cnt_q == CntLast) begin
                  cnt_d   = '0;
                  state_d = StParity;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StParity: begin
               par_bit_d = ser_in;
               state_d   = StStop;
            end
            StStop: begin
               // Expected parity is XOR of data, inverted in odd mode.
               data_d  = shift_q;
               perr_d  = par_bit_q ^ (^shift_q) ^ mode_q;
               ferr_d  = ~ser_in;
               valid_d = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         par_bit_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         par_bit_q <= par_bit_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign par_err    = perr_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_parity_rx.sv
// Testbench for parity_rx: an MSB-first and an LSB-first instance share the
// same serial stimulus; expected words for each are queued per frame and
// popped by a monitor whenever data_valid pulses.
module tb_parity_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, bit_en, ser_in, even_odd;

   logic [7:0] m_data, l_data;
   logic       m_valid, m_perr, m_ferr, m_busy;
   logic       l_valid, l_perr, l_ferr, l_busy;

   parity_rx #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en),
      .ser_in     (ser_in),
      .even_odd   (even_odd),
      .data_out   (m_data),
      .data_valid (m_valid),
      .par_err    (m_perr),
      .frame_err  (m_ferr),
      .busy       (m_busy)
   );

   parity_rx #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en),
      .ser_in     (ser_in),
      .even_odd   (even_odd),
      .data_out   (l_data),
      .data_valid (l_valid),
      .par_err    (l_perr),
      .frame_err  (l_ferr),
      .busy       (l_busy)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t m_q[$];
   exp_t l_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor / scoreboard
   int   cyc      = 0;
   int   busy_cyc = 0;
   int   m_vcnt   = 0;
   int   l_vcnt   = 0;
   int   m_last   = 0;
   int   m_gap    = 0;
   logic m_prev   = 1'b0;
   logic l_prev   = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (m_busy) busy_cyc++;
      if (m_valid) begin
         m_vcnt++;
         m_gap  = cyc - m_last;
         m_last = cyc;
         check("m_valid_single_cycle", {31'd0, m_prev}, 32'd0);
         if (m_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL m_unexpected_valid: got data 0x%0h, expected no pulse", m_data);
         end else begin
            e = m_q.pop_front();
            check("m_data", {24'd0, m_data}, {24'd0, e.data});
            check("m_par_err", {31'd0, m_perr}, {31'd0, e.perr});
            check("m_frame_err", {31'd0, m_ferr}, {31'd0, e.ferr});
         end
      end
      m_prev = m_valid;
      if (l_valid) begin
         l_vcnt++;
         check("l_valid_single_cycle", {31'd0, l_prev}, 32'd0);
         if (l_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL l_unexpected_valid: got data 0x%0h, expected no pulse", l_data);
         end else begin
            e = l_q.pop_front();
            check("l_data", {24'd0, l_data}, {24'd0, e.data});
            check("l_par_err", {31'd0, l_perr}, {31'd0, e.perr});
            check("l_frame_err", {31'd0, l_ferr}, {31'd0, e.ferr});
         end
      end
      l_prev = l_valid;
   end

   // Stimulus
   task automatic step(input logic b, input logic en);
      ser_in = b;
      bit_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0);
   endtask

   // word[7] is the first data bit on the line; lsb_word is what the
   // LSB-first instance must assemble from the same line bits.
   task automatic send_frame(input logic [7:0] word, input logic [7:0] lsb_word,
                             input logic par, input logic stop, input logic mode,
                             input logic flip, input int gap, input logic exp_perr);
      logic [10:0] bits;
      exp_t        em, el;
      bits = {1'b0, word, par, stop};
      em   = '{data: word, perr: exp_perr, ferr: ~stop};
      el   = '{data: lsb_word, perr: exp_perr, ferr: ~stop};
      m_q.push_back(em);
      l_q.push_back(el);
      even_odd = mode;
      for (int i = 10; i >= 0; i--) begin
         if (flip && i == 6) even_odd = ~mode;
         step(bits[i], 1'b1);
         // Strobe-off cycles carry the inverted bit: must be ignored.
         repeat (gap) step(~bits[i], 1'b0);
      end
   endtask

   int v0, b0;

   initial begin
      rst_n    = 1'b0;
      bit_en   = 1'b0;
      ser_in   = 1'b1;
      even_odd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_data", {24'd0, m_data}, 32'd0);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_par_err", {31'd0, m_perr}, 32'd0);
      check("rst_m_frame_err", {31'd0, m_ferr}, 32'd0);
      check("rst_m_busy", {31'd0, m_busy}, 32'd0);
      check("rst_l_data", {24'd0, l_data}, 32'd0);

      rst_n = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("idle_ones_not_busy", {31'd0, m_busy}, 32'd0);

      // Even, no error, strobe every cycle
      v0 = m_vcnt;
      b0 = busy_cyc;
      send_frame(8'hAA, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(3);
      check("t1_busy_cycles", busy_cyc - b0, 32'd10);
      check("t1_pulses", m_vcnt - v0, 32'd1);

      // Odd mode, correct then wrong parity
      send_frame(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
      idle(2);
      send_frame(8'hAA, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
      idle(2);

      // Framing error with gapped strobe
      v0 = m_vcnt;
      send_frame(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
      idle(3);
      check("t4_pulses", m_vcnt - v0, 32'd1);

      // Back-to-back, mode flipped mid-frame on the second
      v0 = m_vcnt;
      send_frame(8'h01, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
      idle(3);
      check("t5_pulses", m_vcnt - v0, 32'd2);
      check("t5_valid_spacing", m_gap, 32'd11);

      // Reset after 4 data bits
      v0       = m_vcnt;
      even_odd = 1'b0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("t6_busy_before_rst", {31'd0, m_busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("t6_rst_m_data", {24'd0, m_data}, 32'd0);
      check("t6_rst_l_data", {24'd0, l_data}, 32'd0);
      check("t6_rst_busy", {31'd0, m_busy}, 32'd0);
      check("t6_rst_valid", {31'd0, m_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("t6_idle_after_rst", {31'd0, m_busy}, 32'd0);
      check("t6_no_pulse", m_vcnt - v0, 32'd0);
      send_frame(8'h55, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(3);

      // Single leading one: LSB-first instance sees 8'h01
      send_frame(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      idle(2);

      // Outputs hold between pulses
      repeat (4) step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      check("hold_m_data", {24'd0, m_data}, 32'h80);
      check("hold_l_data", {24'd0, l_data}, 32'h01);
      check("hold_m_par_err", {31'd0, m_perr}, 32'd0);

      idle(2);
      check("m_queue_drained", m_q.size(), 32'd0);
      check("l_queue_drained", l_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
